// File: rtl/tr_capture_pkg.sv
// Shared defaults and entry layout for the tr_capture transaction recorder.
package tr_capture_pkg;

  localparam int unsigned TRC_DW    = 32;
  localparam int unsigned TRC_DEPTH = 8;
  localparam int unsigned TRC_TSW   = 16;

  typedef struct packed {
    logic [TRC_DW-1:0]  data;
    logic [TRC_TSW-1:0] ts;
  } tr_entry_t;

endpackage

// File: rtl/tr_capture_mem.sv
// Entry storage for tr_capture: one synchronous write port, one asynchronous read port.
module tr_capture_mem #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tr_capture.sv
// Timestamping transaction capture FIFO (first-word-fall-through).
// Define TR_CAPTURE_DROP_EN to drop-and-count on full instead of applying backpressure.
module tr_capture
  import tr_capture_pkg::*;
#(
  parameter int unsigned DW    = TRC_DW,
  parameter int unsigned DEPTH = TRC_DEPTH,
  parameter int unsigned TSW   = TRC_TSW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DW-1:0]            out_data,
  output logic [TSW-1:0]           out_ts,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = DW + TSW;

  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]  count;
  logic [TSW-1:0] ts;
  logic [EW-1:0]  rd_entry;
  logic           full, push, pop;

  assign full      = (count == LW'(DEPTH));
  assign out_valid = (count != '0);
  assign level     = count;
  assign pop       = out_valid && out_ready;

`ifdef TR_CAPTURE_DROP_EN
  logic        drop;
  logic [15:0] drop_q;

  // A pop in the same cycle frees the slot the write lands in, so full+pop is accepted.
  assign in_ready = !rst;
  assign push     = in_valid && in_ready && (!full || pop);
  assign drop     = in_valid && in_ready && full && !pop;
  assign drop_cnt = drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else if (drop && drop_q != '1) begin
      drop_q <= drop_q + 16'd1;
    end
  end
`else
  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready;
  assign drop_cnt = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ts     <= '0;
    end else begin
      ts <= ts + TSW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  tr_capture_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({in_data, ts}),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign out_data = rd_entry[EW-1:TSW];
  assign out_ts   = rd_entry[TSW-1:0];

endmodule

// File: tb/tb_tr_capture.sv
// Directed bench for tr_capture with a queue-based reference model checked every cycle.
module tb_tr_capture;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TSW   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [TSW-1:0] out_ts;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    level;
  logic [15:0]   drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  tr_capture #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .TSW   (TSW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ts    (out_ts),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of {data, ts}; timestamp is the number of cycles since reset release.
  logic [DW+TSW-1:0] mq [$];
  int unsigned       mcyc = 0;
  logic [15:0]       mdrop = '0;
  bit                m_full, m_pop, m_acc;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete();
      mcyc  = 0;
      mdrop = '0;
    end else begin
      m_full = (mq.size() == DEPTH);
      m_pop  = (mq.size() != 0) && out_ready;
`ifdef TR_CAPTURE_DROP_EN
      m_acc = in_valid && (!m_full || m_pop);
      if (in_valid && m_full && !m_pop && mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
`else
      m_acc = in_valid && !m_full;
`endif
      if (m_pop) void'(mq.pop_front());
      if (m_acc) mq.push_back({in_data, TSW'(mcyc % (1 << TSW))});
      mcyc++;
    end
  end

  logic exp_ready;
  initial forever begin
    @(negedge clk);
`ifdef TR_CAPTURE_DROP_EN
    exp_ready = !rst;
`else
    exp_ready = !rst && (mq.size() < DEPTH);
`endif
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, mq.size() != 0);
    chk("level", level, mq.size());
    chk("drop_cnt", drop_cnt, mdrop);
    if (mq.size() != 0) chk("head", {out_data, out_ts}, mq[0]);
  end

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b0;

    // Single push at timestamp 5
    repeat (5) step();
    in_valid = 1'b1;
    in_data  = 32'hA5A5_0001;
    step();
    in_valid = 1'b0;
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 32'hA5A5_0001);
    chk("single_ts", out_ts, 5);
    chk("single_level", level, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_pop_level", level, 0);

    // Fill to full, hold a ninth word, pop one
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'h1000_0000 + i;
      step();
    end
    chk("fill_level", level, 8);
`ifdef TR_CAPTURE_DROP_EN
    chk("fill_in_ready", in_ready, 1);
`else
    chk("fill_in_ready", in_ready, 0);
`endif
    in_data = 32'h1000_0008;
    repeat (2) step();
    chk("held_level", level, 8);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
`ifdef TR_CAPTURE_DROP_EN
    chk("pop1_level", level, 8);
`else
    chk("pop1_level", level, 7);
`endif
    chk("pop1_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("ninth_level", level, 8);

    // Full FIFO, simultaneous push and pop for 20 cycles across pointer wrap
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 32'h2000_0000 + i;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef TR_CAPTURE_DROP_EN
    chk("stream_level", level, 8);
    chk("stream_head", out_data, 32'h2000_000C);
`else
    chk("stream_level", level, 7);
    chk("stream_head", out_data, 32'h2000_000D);
`endif
    out_ready = 1'b1;
    repeat (10) step();
    out_ready = 1'b0;
    chk("drain_level", level, 0);
    chk("drain_valid", out_valid, 0);

`ifdef TR_CAPTURE_DROP_EN
    // Drops on full without pop
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_data = 32'h3000_0000 + i;
      step();
    end
    in_valid = 1'b0;
    chk("drop_cnt3", drop_cnt, 3);
    chk("drop_level", level, 8);
    chk("drop_head", out_data, 32'h3000_0000);
    out_ready = 1'b1;
    repeat (9) step();
    out_ready = 1'b0;
`endif

    // Reset mid-stream with five entries
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'h4000_0000 + i;
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_level", level, 5);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    step();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h4000_00FF;
    step();
    in_valid = 1'b0;
    chk("post_rst_ts", out_ts, 0);
    chk("post_rst_data", out_data, 32'h4000_00FF);
    chk("post_rst_level", level, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Timestamp wrap: push on the 65541st cycle after release stores 65540 mod 65536
    repeat (65538) step();
    in_valid = 1'b1;
    in_data  = 32'h5000_0001;
    step();
    in_valid = 1'b0;
    chk("wrap_ts", out_ts, 4);
    chk("wrap_data", out_data, 32'h5000_0001);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tr_capture.md
TR_CAPTURE -- requirements
Module: tr_capture

Interface
REQ-001 SHALL have parameter DW, default 32, width of captured data word.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries; power of two and at least 2.
REQ-003 SHALL have parameter TSW, default 16, timestamp width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_data  input  DW  transaction data from bus under observation.
REQ-007 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-008 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-009 SHALL have port out_data  output  DW  head entry data.
REQ-010 SHALL have port out_ts  output  TSW  head entry timestamp.
REQ-011 SHALL have port out_valid  output  1  head entry present.
REQ-012 SHALL have port out_ready  input  1  downstream consumer pops head.
REQ-013 SHALL have port level  output  $clog2(DEPTH)+1  current entry count.
REQ-014 SHALL have port drop_cnt  output  16  count of dropped transactions.

Function
REQ-015 SHALL run a free TSW-bit timestamp counter, +1 every cycle, wrapping from all-ones to 0.
REQ-016 SHALL push {in_data, timestamp} when in_valid && in_ready; stored timestamp is the value during the accept cycle.
REQ-017 SHALL pop when out_valid && out_ready.
REQ-018 SHALL be first-word-fall-through: out_data/out_ts show head entry combinationally from storage, held stable while out_valid && !out_ready.
REQ-019 SHALL give push-to-out_valid latency of exactly 1 cycle; no same-cycle bypass when empty.
REQ-020 SHALL assert out_valid iff level != 0.
REQ-021 SHALL update level: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-022 SHALL wrap read/write pointers modulo DEPTH; full is level == DEPTH.
REQ-023 SHALL accept simultaneous push and pop when empty: push stored, pop ignored (out_valid was 0).
REQ-024 SHALL leave storage contents undefined but unobservable when out_valid is 0.

Reset
REQ-025 SHALL, on rst assertion, immediately clear pointers, level, timestamp and drop_cnt; out_valid = 0.
REQ-026 SHALL drive in_ready = 0 while rst is high.
REQ-027 SHALL discard all entries on reset mid-operation; the first push after rst deasserts stores timestamp 0.
REQ-028 SHALL NOT require storage array to be reset.

Configuration
REQ-029 SHALL use macro TR_CAPTURE_DROP_EN.
REQ-030 Without TR_CAPTURE_DROP_EN, SHALL set in_ready = !full (backpressure); drop_cnt SHALL be constant 0.
REQ-031 With TR_CAPTURE_DROP_EN, SHALL set in_ready = 1 outside reset; push on full with simultaneous pop SHALL be accepted with level unchanged.
REQ-032 With TR_CAPTURE_DROP_EN, SHALL discard push on full without pop, incrementing drop_cnt by 1, saturating at 16'hFFFF.

Structure
REQ-033 SHALL place default DW/DEPTH/TSW constants and packed entry struct typedef (data, ts) in package tr_capture_pkg.
REQ-034 SHALL isolate storage in sub-module tr_capture_mem: one write port, one asynchronous read port, DEPTH x entry width.
REQ-035 SHALL keep pointers, level, timestamp and drop logic in tr_capture.

Verification
REQ-036 Reset then single push of 32'hA5A5_0001 at timestamp 5 -> next cycle out_valid=1, out_data=32'hA5A5_0001, out_ts=5, level=1.
REQ-037 Push 8 words with out_ready=0 (no macro) -> level=8, in_ready=0; ninth in_valid held; pop one -> in_ready=1 next cycle.
REQ-038 Full FIFO, simultaneous push and pop for 20 cycles -> level stays 8; data out in exact push order across pointer wrap.
REQ-039 With TR_CAPTURE_DROP_EN, full FIFO, 3 pushes without pop -> drop_cnt=3, level=8, contents unchanged.
REQ-040 Assert rst with level=5 mid-stream -> same cycle out_valid=0, level=0; after release the first push reports out_ts=0.
REQ-041 Run past 2^TSW cycles then push -> out_ts equals wrapped counter value (cycle count mod 65536).
